// File: rtl/device_uart.sv
`default_nettype none
// ============================================================================
// Module      : device_uart
// Description : Device-bus serial port with TX/RX FIFOs and 8N1 framing.
// Revision    : 1.0 - initial release
// ============================================================================
module device_uart #(
    parameter int         CLOCKS_PER_BIT = 434,
    parameter int         FIFO_DEPTH     = 8,
    parameter logic [7:0] BASE_ADDR      = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  device_core_id,
    input  logic        device_write_en,
    input  logic        device_read_en,
    input  logic [9:0]  device_addr,
    input  logic [15:0] device_data_out,
    output logic [15:0] device_data_in,
    output logic        uart_tx,
    input  logic        uart_rx
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_CLK_W = $clog2(CLOCKS_PER_BIT);

    localparam logic [c_CNT_W-1:0] c_DEPTH     = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_CLK_W-1:0] c_BIT_LAST  = c_CLK_W'(CLOCKS_PER_BIT - 1);
    localparam logic [c_CLK_W-1:0] c_HALF_LAST = c_CLK_W'(CLOCKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic       w_hit;
    logic [1:0] w_sel;
    logic       w_tx_wr;
    logic       w_stat_rd;
    logic       w_rx_pop;
    logic       w_unused_data;

    assign w_hit         = (device_addr[9:2] == BASE_ADDR);
    assign w_sel         = device_addr[1:0];
    assign w_tx_wr       = w_hit & device_write_en & (w_sel == 2'd0);
    assign w_stat_rd     = w_hit & device_read_en & (w_sel == 2'd1);
    assign w_unused_data = &{1'b0, device_data_out[15:8]};

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]         r_tx_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_tx_wptr;
    logic [c_PTR_W-1:0] r_tx_rptr;
    logic [c_CNT_W-1:0] r_tx_count;
    logic               w_tx_pop;
    logic               w_tx_accept;
    logic               w_tx_overflow_evt;

    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign w_tx_accept       = w_tx_wr & ((r_tx_count != c_DEPTH) | w_tx_pop);
    assign w_tx_overflow_evt = w_tx_wr & ~w_tx_accept;

    always_ff @(posedge clk) begin
        if (w_tx_accept) begin
            r_tx_mem[r_tx_wptr] <= device_data_out[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_wptr  <= '0;
            r_tx_rptr  <= '0;
            r_tx_count <= '0;
        end else begin
            if (w_tx_accept) r_tx_wptr <= r_tx_wptr + c_PTR_W'(1);
            if (w_tx_pop)    r_tx_rptr <= r_tx_rptr + c_PTR_W'(1);
            case ({w_tx_accept, w_tx_pop})
                2'b10:   r_tx_count <= r_tx_count + c_CNT_W'(1);
                2'b01:   r_tx_count <= r_tx_count - c_CNT_W'(1);
                default: r_tx_count <= r_tx_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    uart_state_t        r_tx_state;
    uart_state_t        w_tx_state_next;
    logic [c_CLK_W-1:0] r_tx_cnt;
    logic [2:0]         r_tx_bit;
    logic [7:0]         r_tx_shift;
    logic [7:0]         w_tx_shift_next;
    logic               w_tx_line_next;
    logic               w_tx_bit_end;
    logic               r_uart_tx;

    assign w_tx_bit_end = (r_tx_cnt == c_BIT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_tx_state <= ST_IDLE;
        else        r_tx_state <= w_tx_state_next;
    end

    always_comb begin
        w_tx_state_next = r_tx_state;
        w_tx_pop        = 1'b0;
        w_tx_shift_next = r_tx_shift;
        w_tx_line_next  = 1'b1;
        case (r_tx_state)
            ST_IDLE: begin
                if (r_tx_count != '0) begin
                    w_tx_pop        = 1'b1;
                    w_tx_shift_next = r_tx_mem[r_tx_rptr];
                    w_tx_state_next = ST_START;
                end
            end
            ST_START: if (w_tx_bit_end) w_tx_state_next = ST_DATA;
            ST_DATA: begin
                if (w_tx_bit_end) begin
                    if (r_tx_bit == 3'd7) w_tx_state_next = ST_STOP;
                    else                  w_tx_shift_next = {1'b0, r_tx_shift[7:1]};
                end
            end
            ST_STOP: if (w_tx_bit_end) w_tx_state_next = ST_IDLE;
            default: w_tx_state_next = ST_IDLE;
        endcase
        // Line level is registered from the next state so the pin never glitches.
        case (w_tx_state_next)
            ST_START: w_tx_line_next = 1'b0;
            ST_DATA:  w_tx_line_next = w_tx_shift_next[0];
            default:  w_tx_line_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_uart_tx  <= 1'b1;
        end else begin
            r_tx_shift <= w_tx_shift_next;
            r_uart_tx  <= w_tx_line_next;
            r_tx_cnt   <= ((r_tx_state == ST_IDLE) || w_tx_bit_end) ? '0 : r_tx_cnt + c_CLK_W'(1);
            if (r_tx_state != ST_DATA) r_tx_bit <= '0;
            else if (w_tx_bit_end)     r_tx_bit <= r_tx_bit + 3'd1;
        end
    end

    assign uart_tx = r_uart_tx;

    // ------------------------------------------------------------------
    // RX synchronizer and FSM
    // ------------------------------------------------------------------
    logic               r_rx_meta;
    logic               r_rx_sync;
    logic               r_rx_prev;
    uart_state_t        r_rx_state;
    uart_state_t        w_rx_state_next;
    logic [c_CLK_W-1:0] r_rx_cnt;
    logic [2:0]         r_rx_bit;
    logic [7:0]         r_rx_shift;
    logic               w_rx_sample;
    logic               w_rx_done;
    logic               w_rx_frame_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= uart_rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    assign w_rx_sample = ((r_rx_state == ST_START) && (r_rx_cnt == c_HALF_LAST)) ||
                         (((r_rx_state == ST_DATA) || (r_rx_state == ST_STOP)) &&
                          (r_rx_cnt == c_BIT_LAST));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_rx_state <= ST_IDLE;
        else        r_rx_state <= w_rx_state_next;
    end

    // Start needs a 1->0 edge, so after a framing error the line must go high first.
    always_comb begin
        w_rx_state_next = r_rx_state;
        w_rx_done       = 1'b0;
        w_rx_frame_err  = 1'b0;
        case (r_rx_state)
            ST_IDLE:  if (r_rx_prev && !r_rx_sync) w_rx_state_next = ST_START;
            ST_START: if (w_rx_sample) w_rx_state_next = r_rx_sync ? ST_IDLE : ST_DATA;
            ST_DATA:  if (w_rx_sample && (r_rx_bit == 3'd7)) w_rx_state_next = ST_STOP;
            ST_STOP: begin
                if (w_rx_sample) begin
                    w_rx_state_next = ST_IDLE;
                    w_rx_done       = r_rx_sync;
                    w_rx_frame_err  = ~r_rx_sync;
                end
            end
            default: w_rx_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            r_rx_cnt <= ((r_rx_state == ST_IDLE) || w_rx_sample) ? '0 : r_rx_cnt + c_CLK_W'(1);
            if (r_rx_state != ST_DATA) r_rx_bit <= '0;
            else if (w_rx_sample)      r_rx_bit <= r_rx_bit + 3'd1;
            if ((r_rx_state == ST_DATA) && w_rx_sample) r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    logic [7:0]         r_rx_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_rx_wptr;
    logic [c_PTR_W-1:0] r_rx_rptr;
    logic [c_CNT_W-1:0] r_rx_count;
    logic               w_rx_push;
    logic               w_rx_overrun_evt;
    logic               w_rx_avail;

    assign w_rx_avail       = (r_rx_count != '0);
    assign w_rx_pop         = w_hit & device_read_en & (w_sel == 2'd2) & w_rx_avail;
    assign w_rx_push        = w_rx_done & ((r_rx_count != c_DEPTH) | w_rx_pop);
    assign w_rx_overrun_evt = w_rx_done & ~w_rx_push;

    always_ff @(posedge clk) begin
        if (w_rx_push) begin
            r_rx_mem[r_rx_wptr] <= r_rx_shift;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_wptr  <= '0;
            r_rx_rptr  <= '0;
            r_rx_count <= '0;
        end else begin
            if (w_rx_push) r_rx_wptr <= r_rx_wptr + c_PTR_W'(1);
            if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + c_PTR_W'(1);
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_count <= r_rx_count + c_CNT_W'(1);
                2'b01:   r_rx_count <= r_rx_count - c_CNT_W'(1);
                default: r_rx_count <= r_rx_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Status, sticky flags and registered read data
    // ------------------------------------------------------------------
    logic        r_tx_overflow;
    logic        r_rx_overrun;
    logic        r_framing_err;
    logic [3:0]  r_last_core;
    logic [15:0] w_status;
    logic [15:0] w_rdata;
    logic [15:0] r_rdata;

    assign w_status = {4'h0, r_last_core, r_framing_err, r_rx_overrun, r_tx_overflow,
                       (r_rx_count == c_DEPTH), w_rx_avail, (r_tx_state != ST_IDLE),
                       (r_tx_count == '0), (r_tx_count == c_DEPTH)};

    always_comb begin
        w_rdata = 16'h0000;
        if (w_hit) begin
            case (w_sel)
                2'd1:    w_rdata = w_status;
                2'd2:    w_rdata = w_rx_avail ? {8'h00, r_rx_mem[r_rx_rptr]} : 16'h0000;
                default: w_rdata = 16'h0000;
            endcase
        end
    end

    // A same-cycle event outranks the clear-on-read of STATUS.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_overflow <= 1'b0;
            r_rx_overrun  <= 1'b0;
            r_framing_err <= 1'b0;
            r_last_core   <= 4'h0;
            r_rdata       <= 16'h0000;
        end else begin
            r_tx_overflow <= w_tx_overflow_evt | (r_tx_overflow & ~w_stat_rd);
            r_rx_overrun  <= w_rx_overrun_evt  | (r_rx_overrun  & ~w_stat_rd);
            r_framing_err <= w_rx_frame_err    | (r_framing_err & ~w_stat_rd);
            if (w_tx_accept)    r_last_core <= device_core_id;
            if (device_read_en) r_rdata     <= w_rdata;
        end
    end

    assign device_data_in = r_rdata;

endmodule
`default_nettype wire
